fetch_unit: RTL and testbench

Instruction-fetch initiator for the pipelined MIPS core. It owns the program counter and drives the fetch memory's read address. It captures the returned instruction into the IF/ID register. It handles boot, decode stall, branch redirect (with delay slot) and exception vectoring into the IVT. The block sits between the fetch memory (combinational read responder) and the decode stage.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_addr_check.sv | 22 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch unit: memory map
// bounds (word addresses), FSM state encoding, and the IVT vector helper.
package fetch_unit_pkg;

  // Text segment, word addresses (byte 0x100 .. 0x3FC)
  localparam logic [31:0] TEXT_DAT_BOT = 32'h0000_0040;
  localparam logic [31:0] TEXT_DAT_TOP = 32'h0000_00FF;

  // Interrupt vector table, word addresses (byte 0x40 .. 0x5C)
  localparam logic [31:0] IVT_BOT      = 32'h0000_0010;
  localparam logic [31:0] IVT_TOP      = 32'h0000_0017;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // Byte address of IVT entry 'cause'; cause is already zero-extended.
  function automatic logic [31:0] ivt_vector(input logic [31:0] base,
                                             input logic [31:0] cause);
    return base + (cause << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_addr_check.sv
// Combinational fetch-address classifier: flags misaligned PCs and PCs whose
// word address lies outside both the text segment and the IVT. Kept free of
// fetch state so data-memory fault logic can reuse it.
module fetch_addr_check
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  output logic        o_bad_align,
  output logic        o_bad_range
);

  logic [31:0] w_word;
  logic        w_in_text;
  logic        w_in_ivt;

  assign w_word      = {2'b00, i_pc[31:2]};
  assign w_in_text   = (w_word >= TEXT_DAT_BOT) && (w_word <= TEXT_DAT_TOP);
  assign w_in_ivt    = (w_word >= IVT_BOT) && (w_word <= IVT_TOP);
  assign o_bad_align = (i_pc[1:0] != 2'b00);
  assign o_bad_range = !(w_in_text || w_in_ivt);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, presents it to a combinational
// fetch memory, captures the returned word into IF/ID, and handles boot,
// stall, delayed branches, bad-PC faults and exception vectoring.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] IVT_BASE    = IVT_BOT << 2,
  parameter int          NUM_VECTORS = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    start_addr,
  output logic [31:0]                    readAddress,
  input  logic [31:0]                    memInstruction,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [31:0]                    branch_target,
  input  logic                           exception,
  input  logic [$clog2(NUM_VECTORS)-1:0] exception_cause,
  output logic [31:0]                    instruction,
  output logic [31:0]                    instr_pc,
  output logic                           instr_valid,
  output logic                           fetch_fault,
  output logic [31:0]                    fault_addr
);

  fetch_state_e r_state, w_state_nxt;

  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_instr_p1,   w_instr_nxt;
  logic [31:0] r_ipc_p1,     w_ipc_nxt;
  logic        r_vld_p1,     w_vld_nxt;
  logic        r_fault,      w_fault_nxt;
  logic [31:0] r_fault_addr, w_fault_addr_nxt;

  logic        w_bad_align;
  logic        w_bad_range;
  logic [31:0] w_vector;

  // Checks look only at the registered PC, so memInstruction never reaches
  // readAddress combinationally.
  fetch_addr_check u_addr_check (
    .i_pc        (r_pc),
    .o_bad_align (w_bad_align),
    .o_bad_range (w_bad_range)
  );

  assign w_vector = ivt_vector(IVT_BASE, 32'(exception_cause));

  // Next-state and next-register selection; every register holds by default.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr_p1;
    w_ipc_nxt        = r_ipc_p1;
    w_vld_nxt        = r_vld_p1;
    w_fault_nxt      = r_fault;
    w_fault_addr_nxt = r_fault_addr;
    unique case (r_state)
      FETCH_BOOT: begin
        w_pc_nxt    = start_addr & ~32'h3;
        w_vld_nxt   = 1'b0;
        w_state_nxt = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (exception) begin
          // Squash the slot being fetched and vector into the IVT
          w_pc_nxt  = w_vector;
          w_vld_nxt = 1'b0;
        end else if (w_bad_align || w_bad_range) begin
          w_state_nxt      = FETCH_FAULT;
          w_fault_nxt      = 1'b1;
          w_fault_addr_nxt = r_pc;
          w_vld_nxt        = 1'b0;
        end else if (!stall) begin
          // The word fetched in a redirect cycle is the delay slot
          w_instr_nxt = memInstruction;
          w_ipc_nxt   = r_pc;
          w_vld_nxt   = 1'b1;
          w_pc_nxt    = branch_taken ? branch_target : r_pc + 32'd4;
        end
      end
      FETCH_FAULT: begin
        w_vld_nxt = 1'b0;
        if (exception) begin
          w_pc_nxt    = w_vector;
          w_fault_nxt = 1'b0;
          w_state_nxt = FETCH_RUN;
        end
      end
      default: begin
        w_state_nxt = FETCH_BOOT;
      end
    endcase
  end

  // State and IF/ID registers, synchronously reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FETCH_BOOT;
      r_pc         <= 32'd0;
      r_instr_p1   <= 32'd0;
      r_ipc_p1     <= 32'd0;
      r_vld_p1     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr_p1   <= w_instr_nxt;
      r_ipc_p1     <= w_ipc_nxt;
      r_vld_p1     <= w_vld_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_addr <= w_fault_addr_nxt;
    end
  end

  assign readAddress = r_pc;
  assign instruction = r_instr_p1;
  assign instr_pc    = r_ipc_p1;
  assign instr_valid = r_vld_p1;
  assign fetch_fault = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed walk through boot, stall, delayed branch,
// exception and fault scenarios, then randomized traffic, all checked each
// cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] TB_IVT_BASE = IVT_BOT * 4;

  logic        clock;
  logic        reset;
  logic [31:0] start_addr;
  logic [31:0] read_address;
  logic [31:0] mem_instr;
  logic        stall;
  logic        br;
  logic [31:0] btgt;
  logic        exc;
  logic [2:0]  cause;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fault_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: mode 0=boot, 1=running, 2=faulted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_faddr;
  logic        m_vld, m_fault;

  fetch_unit #(.IVT_BASE(TB_IVT_BASE), .NUM_VECTORS(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_addr      (start_addr),
    .readAddress     (read_address),
    .memInstruction  (mem_instr),
    .stall           (stall),
    .branch_taken    (br),
    .branch_target   (btgt),
    .exception       (exc),
    .exception_cause (cause),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .fetch_fault     (fetch_fault),
    .fault_addr      (fault_addr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign mem_instr = mem_word(read_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit fetchable(input logic [31:0] a);
    logic [31:0] w;
    if (a % 4 != 0) return 1'b0;
    w = a / 4;
    return (w >= TEXT_DAT_BOT && w <= TEXT_DAT_TOP) || (w >= IVT_BOT && w <= IVT_TOP);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0;
      m_vld = 0; m_fault = 0; m_faddr = 0;
    end else if (m_mode == 0) begin
      m_pc   = start_addr - (start_addr % 4);
      m_vld  = 0;
      m_mode = 1;
    end else if (exc) begin
      m_pc    = TB_IVT_BASE + 4 * 32'(cause);
      m_vld   = 0;
      m_fault = 0;
      m_mode  = 1;
    end else if (m_mode == 2) begin
      m_vld = 0;
    end else if (!fetchable(m_pc)) begin
      m_mode  = 2;
      m_fault = 1;
      m_faddr = m_pc;
      m_vld   = 0;
    end else if (!stall) begin
      m_instr = mem_word(m_pc);
      m_ipc   = m_pc;
      m_vld   = 1;
      m_pc    = br ? btgt : m_pc + 4;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_eq("readAddress", read_address, m_pc);
    check_eq("instruction", instruction, m_instr);
    check_eq("instr_pc", instr_pc, m_ipc);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_vld));
    check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check_eq("fault_addr", fault_addr, m_faddr);
  endtask

  task automatic quiet();
    stall = 0; br = 0; exc = 0; cause = 0; btgt = 0;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0: return 32'($urandom_range(64, 255)) << 2;
      1: return 32'($urandom_range(16, 23)) << 2;
      2: return (32'($urandom_range(64, 255)) << 2) + 32'($urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit done;
    reset = 1; start_addr = 32'h0000_0103; quiet();

    // Reset state
    step(); step();
    check_eq("rst_readAddress", read_address, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'h0);

    // Boot and first fetches
    reset = 0;
    step();
    check_eq("boot_pc", read_address, 32'h100);
    check_eq("boot_valid", 32'(instr_valid), 32'h0);
    step();
    check_eq("first_valid", 32'(instr_valid), 32'h1);
    check_eq("first_ipc", instr_pc, 32'h100);
    step();
    check_eq("second_ipc", instr_pc, 32'h104);

    // Stall with a branch request that must be ignored
    stall = 1; br = 1; btgt = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_ipc", instr_pc, 32'h104);
      check_eq("stall_pc", read_address, 32'h108);
    end

    // Delayed branch from 0x108 to 0x200
    stall = 0; br = 1; btgt = 32'h200;
    step();
    check_eq("slot_ipc", instr_pc, 32'h108);
    check_eq("slot_valid", 32'(instr_valid), 32'h1);
    check_eq("branch_pc", read_address, 32'h200);
    quiet();
    step();
    check_eq("target_ipc", instr_pc, 32'h200);

    // Exception beats concurrent stall and branch
    exc = 1; cause = 3; stall = 1; br = 1; btgt = 32'h300;
    step();
    check_eq("exc_pc", read_address, TB_IVT_BASE + 32'h0C);
    check_eq("exc_squash", 32'(instr_valid), 32'h0);
    quiet();
    step();
    check_eq("vec_ipc", instr_pc, TB_IVT_BASE + 32'h0C);
    check_eq("vec_valid", 32'(instr_valid), 32'h1);

    // Misaligned branch target faults one cycle after it lands
    br = 1; btgt = 32'h202;
    step();
    quiet();
    step();
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom_range(1)); br = 1'($urandom_range(1)); btgt = 32'h100;
      check_eq("mis_fault", 32'(fetch_fault), 32'h1);
      check_eq("mis_faddr", fault_addr, 32'h202);
      check_eq("mis_valid", 32'(instr_valid), 32'h0);
      step();
    end
    quiet(); exc = 1; cause = 0;
    step();
    check_eq("clr_fault", 32'(fetch_fault), 32'h0);
    check_eq("clr_pc", read_address, TB_IVT_BASE);
    quiet();
    step();
    check_eq("clr_ipc", instr_pc, TB_IVT_BASE);

    // Run off the top of the text segment
    br = 1; btgt = (TEXT_DAT_TOP << 2) - 32'hC;
    step();
    quiet();
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (fetch_fault) done = 1;
    end
    check_eq("top_fault_seen", 32'(done), 32'h1);
    check_eq("top_faddr", fault_addr, (TEXT_DAT_TOP + 1) << 2);

    // Reset in the middle of a fault
    reset = 1;
    step();
    check_eq("rst2_pc", read_address, 32'h0);
    check_eq("rst2_fault", 32'(fetch_fault), 32'h0);
    check_eq("rst2_faddr", fault_addr, 32'h0);
    check_eq("rst2_instr", instruction, 32'h0);
    check_eq("rst2_ipc", instr_pc, 32'h0);
    check_eq("rst2_valid", 32'(instr_valid), 32'h0);
    reset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(99) == 0);
      start_addr = ($urandom_range(3) == 0) ? $urandom
                                            : (32'($urandom_range(64, 255)) << 2) + 32'($urandom_range(3));
      exc        = ($urandom_range(29) == 0);
      cause      = 3'($urandom_range(7));
      stall      = ($urandom_range(3) == 0);
      br         = ($urandom_range(6) == 0);
      btgt       = pick_target();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
